// File: rtl/remote_comm.sv
// remote_comm: ground-side UART command link.
// Sends a 3-byte frame {cmd, data[15:8], data[7:0]} (8N1, LSB first) on TX
// when snd_cmd is accepted, then waits up to TIMEOUT cycles for one response
// byte on RX.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   snd_cmd, cmd, data send request and frame contents (sampled on accept)
//   RX / TX           serial input from / output to the copter
//   busy              high from accept until resp_rdy or timeout
//   cmd_sent          pulse at the end of the last stop bit
//   resp_rdy, resp    pulse + captured response byte (resp holds)
//   timeout           pulse when no response arrived in time
module remote_comm #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned TIMEOUT  = 4194304
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        timeout
);

  localparam int unsigned BW = $clog2(BAUD_DIV + 1);
  localparam int unsigned TW = 23;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX_CMD    = 3'd1,
    TX_DHI    = 3'd2,
    TX_DLO    = 3'd3,
    WAIT_RESP = 3'd4
  } state_t;

  state_t          state_q;
  logic            tx_q;
  logic            busy_q;
  logic            cmd_sent_q;
  logic            resp_rdy_q;
  logic            timeout_q;
  logic [7:0]      resp_q;
  logic [23:0]     shadow_q;
  logic [BW-1:0]   tx_baud_q;
  logic [3:0]      tx_bit_q;
  logic [TW-1:0]   wait_cnt_q;

  logic            rx_s1_q;
  logic            rx_s2_q;
  logic            rx_prev_q;
  logic            rx_act_q;
  logic [BW-1:0]   rx_baud_q;
  logic [3:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;

  logic [7:0]      cur_byte_c;
  logic            rx_done_c;

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign cmd_sent = cmd_sent_q;
  assign resp_rdy = resp_rdy_q;
  assign resp     = resp_q;
  assign timeout  = timeout_q;

  // Byte of the shadow register currently being serialised
  always_comb begin
    cur_byte_c = shadow_q[7:0];
    case (state_q)
      TX_CMD:  cur_byte_c = shadow_q[23:16];
      TX_DHI:  cur_byte_c = shadow_q[15:8];
      default: cur_byte_c = shadow_q[7:0];
    endcase
  end

  // A clean byte completes when the stop bit is sampled high
  assign rx_done_c = rx_act_q && (rx_baud_q == HALF_LAST) &&
                     (rx_bit_q == 4'd9) && rx_s2_q;

  // Receiver: free-running, mid-bit sampling relative to the detected edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_act_q  <= 1'b0;
      rx_baud_q <= '0;
      rx_bit_q  <= 4'd0;
      rx_sh_q   <= 8'h00;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (!rx_act_q) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_act_q  <= 1'b1;
          rx_baud_q <= '0;
          rx_bit_q  <= 4'd0;
        end
      end else begin
        rx_baud_q <= (rx_baud_q == BAUD_LAST) ? '0 : rx_baud_q + BW'(1);
        if (rx_baud_q == HALF_LAST) begin
          if (rx_bit_q == 4'd0) begin
            // start bit read back high: treat as a glitch
            if (rx_s2_q) rx_act_q <= 1'b0;
          end else if (rx_bit_q <= 4'd8) begin
            rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
          end else begin
            // stop bit: either good (rx_done_c) or framing error, both end the frame
            rx_act_q <= 1'b0;
          end
          if (rx_bit_q != 4'd9) rx_bit_q <= rx_bit_q + 4'd1;
        end
      end
    end
  end

  // Command FSM: transmit three bytes, then wait for the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
      resp_rdy_q <= 1'b0;
      timeout_q  <= 1'b0;
      resp_q     <= 8'h00;
      shadow_q   <= 24'h000000;
      tx_baud_q  <= '0;
      tx_bit_q   <= 4'd0;
      wait_cnt_q <= '0;
    end else begin
      cmd_sent_q <= 1'b0;
      resp_rdy_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (snd_cmd) begin
            shadow_q  <= {cmd, data};
            busy_q    <= 1'b1;
            tx_q      <= 1'b0;
            tx_baud_q <= '0;
            tx_bit_q  <= 4'd0;
            state_q   <= TX_CMD;
          end
        end
        TX_CMD, TX_DHI, TX_DLO: begin
          if (tx_baud_q == BAUD_LAST) begin
            tx_baud_q <= '0;
            if (tx_bit_q == 4'd9) begin
              tx_bit_q <= 4'd0;
              if (state_q == TX_DLO) begin
                cmd_sent_q <= 1'b1;
                wait_cnt_q <= '0;
                state_q    <= WAIT_RESP;
              end else begin
                // next byte starts immediately, no idle bits
                tx_q    <= 1'b0;
                state_q <= (state_q == TX_CMD) ? TX_DHI : TX_DLO;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
              tx_q     <= (tx_bit_q == 4'd8) ? 1'b1 : cur_byte_c[tx_bit_q[2:0]];
            end
          end else begin
            tx_baud_q <= tx_baud_q + BW'(1);
          end
        end
        WAIT_RESP: begin
          wait_cnt_q <= wait_cnt_q + TW'(1);
          // a byte landing on the timeout cycle takes priority
          if (rx_done_c) begin
            resp_q     <= rx_sh_q;
            resp_rdy_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (wait_cnt_q == TO_LAST) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: cycle model of the command link plus a UART
// decoder on TX and a UART driver on RX.
module tb_remote_comm;

  localparam int B  = 16;
  localparam int TO = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        RX;
  logic        TX, busy, cmd_sent, resp_rdy, timeout;
  logic [7:0]  resp;

  remote_comm #(.BAUD_DIV(B), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
    .RX(RX), .TX(TX), .busy(busy), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model state: phase 0 idle, 1 sending, 2 waiting for response
  int          m_phase = 0;
  int          m_n = 0;
  logic [23:0] m_frame = '0;
  logic [7:0]  m_resp = 8'h00;
  logic        p_snd = 1'b0;
  logic [7:0]  p_cmd = '0;
  logic [15:0] p_data = '0;
  logic        exp_cs, exp_to, exp_rr;

  // response the RX driver has sent, with the cycle window it must land in
  bit          rsp_pending = 0;
  logic [7:0]  rsp_byte = '0;
  int          rsp_lo = 0, rsp_hi = 0;

  int   cs_count = 0, rr_count = 0, to_count = 0;
  int   cs_cyc = 0, rr_cyc = 0, to_cyc = 0;
  logic rr_busy = 1'b1;

  logic [7:0] txq[$];
  int acc_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic logic model_tx();
    int idx, pos;
    logic [7:0] bt;
    if (m_phase != 1) return 1'b1;
    idx = m_n / (10 * B);
    pos = (m_n / B) % 10;
    bt  = m_frame[(23 - 8 * idx) -: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return bt[pos - 1];
  endfunction

  // Model step for the edge just passed, then compare every output
  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0; m_n = 0; m_resp = 8'h00;
      p_snd = 1'b0; rsp_pending = 0;
    end else begin
      exp_cs = 1'b0; exp_to = 1'b0; exp_rr = 1'b0;
      if (rsp_pending && cyc > rsp_hi) begin
        rsp_pending = 0;
        if (m_phase == 2) begin
          checks++; errors++;
          $display("FAIL resp_missing: no resp_rdy by cycle %0d, expected byte %0h", rsp_hi, rsp_byte);
        end
      end
      case (m_phase)
        0: if (p_snd) begin m_phase = 1; m_n = 0; m_frame = {p_cmd, p_data}; end
        1: begin
          m_n++;
          if (m_n == 30 * B) begin m_phase = 2; m_n = 0; exp_cs = 1'b1; end
        end
        default: begin
          if (resp_rdy && rsp_pending && cyc >= rsp_lo && cyc <= rsp_hi) begin
            m_phase = 0; m_resp = rsp_byte; exp_rr = 1'b1; rsp_pending = 0;
          end else begin
            m_n++;
            if (m_n == TO) begin m_phase = 0; exp_to = 1'b1; end
          end
        end
      endcase
      chk("tx", 32'(TX), 32'(model_tx()));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("cmd_sent", 32'(cmd_sent), 32'(exp_cs));
      chk("timeout", 32'(timeout), 32'(exp_to));
      chk("resp_rdy", 32'(resp_rdy), 32'(exp_rr));
      chk("resp", 32'(resp), 32'(m_resp));
      if (cmd_sent) begin cs_count++; cs_cyc = cyc; end
      if (resp_rdy) begin rr_count++; rr_cyc = cyc; rr_busy = busy; end
      if (timeout)  begin to_count++; to_cyc = cyc; end
      p_snd = snd_cmd; p_cmd = cmd; p_data = data;
    end
  end

  // UART decoder on TX: mid-bit sampling, good bytes queued
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && TX == 1'b0) begin
        repeat (B / 2) @(negedge clk);
        if (TX == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            b[i] = TX;
          end
          repeat (B) @(negedge clk);
          if (TX == 1'b1) txq.push_back(b);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [15:0] d);
    @(posedge clk); #2;
    snd_cmd = 1'b1; cmd = c; data = d;
    acc_cyc = cyc + 1;
    @(posedge clk); #2;
    snd_cmd = 1'b0; cmd = 8'($urandom); data = 16'($urandom);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic stop, input bit expect_resp);
    @(posedge clk); #2;
    if (expect_resp) begin
      rsp_byte = b;
      rsp_lo = cyc + 1 + 9 * B + B / 2;
      rsp_hi = rsp_lo + 4;
      rsp_pending = 1;
    end
    RX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(posedge clk); #2;
      RX = b[i];
    end
    repeat (B) @(posedge clk); #2;
    RX = stop;
    repeat (B) @(posedge clk); #2;
    RX = 1'b1;
  endtask

  task automatic wait_evt(input int which, input int snap, input int maxc);
    bit got;
    int n;
    got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      n = (which == 0) ? cs_count : (which == 1) ? rr_count : to_count;
      if (n > snap) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wait_event_%0d: none within %0d cycles", which, maxc);
    end
  endtask

  task automatic chk_frame(input logic [7:0] c, input logic [15:0] d);
    logic [7:0] e [3];
    e[0] = c; e[1] = d[15:8]; e[2] = d[7:0];
    chk("frame_len", 32'(txq.size()), 32'd3);
    for (int i = 0; i < 3 && i < txq.size(); i++) chk("frame_byte", 32'(txq[i]), 32'(e[i]));
    txq.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx"}, 32'(TX), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cmd_sent"}, 32'(cmd_sent), 32'd0);
    chk({tag, "_resp_rdy"}, 32'(resp_rdy), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_resp"}, 32'(resp), 32'h00);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, snap_cs, a, mode;
    logic [7:0] c, rb;
    logic [15:0] d;
    rst = 1'b1; snd_cmd = 1'b0; RX = 1'b1; cmd = 8'h00; data = 16'h0000;
    repeat (3) @(posedge clk); #2;
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // frame 02 12 34 with an ignored request mid-frame
    snap_cs = cs_count;
    send(8'h02, 16'h1234);
    a = acc_cyc;
    repeat (100) @(posedge clk); #2;
    snd_cmd = 1'b1; cmd = 8'h05; data = 16'hBEEF;
    @(posedge clk); #2;
    snd_cmd = 1'b0;
    wait_evt(0, snap_cs, 30 * B + 20);
    chk("cmd_sent_latency", 32'(cs_cyc - a), 32'd480);
    chk_frame(8'h02, 16'h1234);

    // A5 acknowledge
    repeat (20) @(posedge clk);
    snap = rr_count;
    drive_byte(8'hA5, 1'b1, 1);
    wait_evt(1, snap, 20);
    chk("resp_a5", 32'(resp), 32'hA5);
    chk("resp_rdy_once", 32'(rr_count - snap), 32'd1);
    chk("busy_at_resp", 32'(rr_busy), 32'd0);
    chk("cmd_sent_once", 32'(cs_count - snap_cs), 32'd1);

    // no reply: timeout
    snap_cs = cs_count;
    send(8'h11, 16'h2233);
    wait_evt(0, snap_cs, 30 * B + 20);
    chk_frame(8'h11, 16'h2233);
    snap = to_count;
    wait_evt(2, snap, TO + 20);
    chk("timeout_latency", 32'(to_cyc - cs_cyc), 32'd4000);
    chk("resp_held", 32'(resp), 32'hA5);
    chk("busy_after_timeout", 32'(busy), 32'd0);

    // framing error and glitch dropped, clean byte accepted
    snap_cs = cs_count;
    send(8'h40, 16'h0001);
    wait_evt(0, snap_cs, 30 * B + 20);
    chk_frame(8'h40, 16'h0001);
    repeat (5) @(posedge clk);
    snap = rr_count;
    drive_byte(8'h3C, 1'b0, 0);
    repeat (10) @(posedge clk); #2;
    RX = 1'b0;
    repeat (4) @(posedge clk); #2;
    RX = 1'b1;
    repeat (40) @(posedge clk);
    chk("no_resp_bad_frames", 32'(rr_count - snap), 32'd0);
    drive_byte(8'h3C, 1'b1, 1);
    wait_evt(1, snap, 20);
    chk("resp_3c", 32'(resp), 32'h3C);

    // byte while idle is discarded
    repeat (10) @(posedge clk);
    snap = rr_count;
    drive_byte(8'h99, 1'b1, 0);
    repeat (10) @(posedge clk);
    chk("idle_byte_dropped", 32'(rr_count - snap), 32'd0);
    chk("idle_resp_held", 32'(resp), 32'h3C);

    // randomized transactions
    for (int it = 0; it < 10; it++) begin
      c = 8'($urandom); d = 16'($urandom);
      snap_cs = cs_count;
      send(c, d);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 400)) @(posedge clk); #2;
        snd_cmd = 1'b1; cmd = ~c; data = ~d;
        @(posedge clk); #2;
        snd_cmd = 1'b0;
      end
      wait_evt(0, snap_cs, 30 * B + 20);
      chk("rnd_cmd_sent_once", 32'(cs_count - snap_cs), 32'd1);
      chk_frame(c, d);
      mode = int'($urandom_range(0, 5));
      if (mode == 0) begin
        snap = to_count;
        wait_evt(2, snap, TO + 20);
        chk("rnd_timeout_latency", 32'(to_cyc - cs_cyc), 32'(TO));
      end else begin
        repeat ($urandom_range(1, 300)) @(posedge clk);
        snap = rr_count;
        if (mode == 1) begin
          drive_byte(8'($urandom), 1'b0, 0);
          repeat (5) @(posedge clk);
        end
        rb = 8'($urandom);
        drive_byte(rb, 1'b1, 1);
        wait_evt(1, snap, 20);
        chk("rnd_resp", 32'(resp), 32'(rb));
      end
      repeat ($urandom_range(1, 20)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) begin
        snap = rr_count;
        drive_byte(8'($urandom), 1'b1, 0);
        repeat (10) @(posedge clk);
        chk("rnd_idle_drop", 32'(rr_count - snap), 32'd0);
      end
    end

    // reset during the second byte, then a fresh frame
    snap_cs = cs_count;
    send(8'h77, 16'h8899);
    repeat (15 * B) @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midframe_rst");
    repeat (3) @(posedge clk); #2;
    rst = 1'b0;
    repeat (200) @(posedge clk);
    chk("no_cmd_sent_after_abort", 32'(cs_count - snap_cs), 32'd0);
    txq.delete();
    snap_cs = cs_count;
    send(8'h5A, 16'hC3E1);
    a = acc_cyc;
    wait_evt(0, snap_cs, 30 * B + 20);
    chk("post_rst_latency", 32'(cs_cyc - a), 32'd480);
    chk_frame(8'h5A, 16'hC3E1);
    snap = rr_count;
    drive_byte(8'h81, 1'b1, 1);
    wait_evt(1, snap, 20);
    chk("post_rst_resp", 32'(resp), 32'h81);
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
